// File: rtl/ads_sample_seq.sv
// Upstream sequencer for the ADS I2C controller: one config write, then periodic conversion
// reads, stability-qualified capture of ad_voltage, and a block average of the captured samples.
module ads_sample_seq #(
    parameter int unsigned REQ_LEN       = 4,
    parameter int unsigned TXN_WAIT      = 6000,
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter int unsigned STABLE_CYC    = 150,
    parameter int unsigned AVG_LOG2      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] ad_voltage,
    output logic        wr_req,
    output logic        rd_req,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        sample_zero,
    output logic [15:0] avg,
    output logic        avg_valid,
    output logic        cfg_done,
    output logic        busy
);

    localparam int unsigned AccW = 16 + AVG_LOG2;
    localparam int unsigned RunW = $clog2(STABLE_CYC + 1);

    localparam logic [31:0]       ReqLast = 32'(REQ_LEN - 1);
    localparam logic [31:0]       TxnLast = 32'(TXN_WAIT - 1);
    localparam logic [31:0]       PerLast = 32'(SAMPLE_PERIOD - 1);
    localparam logic [RunW-1:0]   RunMax  = RunW'(STABLE_CYC);
    localparam logic [AVG_LOG2:0] BlkLen  = {1'b1, {AVG_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StCfgReq,
        StCfgWait,
        StPerWait,
        StRdReq,
        StRdWait,
        StEmit
    } state_e;

    state_e state_q, state_d;
    logic [31:0] timer_q, timer_d;

    logic [15:0]      prev_q;
    logic [RunW-1:0]  run_q, run_d;
    logic [15:0]      cand_q, cand_d;
    logic             found_q, found_d;

    logic signed [AccW-1:0] acc_q, acc_d;
    logic [AVG_LOG2:0]      cnt_q, cnt_d;

    logic [15:0] sample_q, sample_d;
    logic        sample_valid_q, sample_valid_d;
    logic        sample_zero_q, sample_zero_d;
    logic [15:0] avg_q, avg_d;
    logic        avg_valid_q, avg_valid_d;
    logic        cfg_done_q, cfg_done_d;

    logic                   cfg_set, win_start, win_end, to_idle;
    logic [15:0]            new_sample;
    logic signed [AccW-1:0] acc_sum;
    logic signed [AccW-1:0] acc_shr;

    // Sequencing FSM; one shared timer restarts at every state change
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 32'd1;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (en) state_d = cfg_done_q ? StPerWait : StCfgReq;
            end
            StCfgReq: begin
                if (timer_q == ReqLast) begin
                    state_d = StCfgWait;
                    timer_d = '0;
                end
            end
            StCfgWait: begin
                if (timer_q == TxnLast) begin
                    state_d = StPerWait;
                    timer_d = '0;
                end
            end
            StPerWait: begin
                if (!en) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else if (timer_q == PerLast) begin
                    state_d = StRdReq;
                    timer_d = '0;
                end
            end
            StRdReq: begin
                if (timer_q == ReqLast) begin
                    state_d = StRdWait;
                    timer_d = '0;
                end
            end
            StRdWait: begin
                if (timer_q == TxnLast) begin
                    state_d = StEmit;
                    timer_d = '0;
                end
            end
            StEmit: begin
                timer_d = '0;
                state_d = en ? StPerWait : StIdle;
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    assign cfg_set   = (state_q == StCfgWait) && (timer_q == TxnLast);
    assign win_start = (state_q == StRdReq) && (timer_q == ReqLast);
    assign win_end   = (state_q == StRdWait) && (timer_q == TxnLast);
    assign to_idle   = (state_d == StIdle) && ((state_q == StPerWait) || (state_q == StEmit));

    // Stability tracker: the controller gives no done strobe, so a value counts only once it
    // has held long enough to outlast a single SCL bit of the shift-in.
    always_comb begin
        run_d   = run_q;
        cand_d  = cand_q;
        found_d = found_q;
        if (win_start) begin
            run_d   = '0;
            cand_d  = '0;
            found_d = 1'b0;
        end else if (state_q == StRdWait) begin
            if (ad_voltage != prev_q) begin
                run_d = '0;
            end else if (run_q != RunMax) begin
                run_d = run_q + 1'b1;
                if (run_d == RunMax && ad_voltage != 16'h0000) begin
                    cand_d  = ad_voltage;
                    found_d = 1'b1;
                end
            end
        end
    end

    // Emit and block averaging; the last window cycle's qualification still counts
    assign new_sample = found_d ? cand_d : 16'h0000;
    assign acc_sum    = acc_q + {{AVG_LOG2{new_sample[15]}}, new_sample};
    assign acc_shr    = acc_sum >>> AVG_LOG2;

    always_comb begin
        sample_d       = sample_q;
        sample_zero_d  = sample_zero_q;
        sample_valid_d = 1'b0;
        avg_d          = avg_q;
        avg_valid_d    = 1'b0;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        cfg_done_d     = cfg_done_q | cfg_set;
        if (win_end) begin
            sample_d       = new_sample;
            sample_zero_d  = ~found_d;
            sample_valid_d = 1'b1;
            if (cnt_q + 1'b1 == BlkLen) begin
                avg_d       = acc_shr[15:0];
                avg_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end else if (to_idle) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            prev_q         <= '0;
            run_q          <= '0;
            cand_q         <= '0;
            found_q        <= 1'b0;
            acc_q          <= '0;
            cnt_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            sample_zero_q  <= 1'b0;
            avg_q          <= '0;
            avg_valid_q    <= 1'b0;
            cfg_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            prev_q         <= ad_voltage;
            run_q          <= run_d;
            cand_q         <= cand_d;
            found_q        <= found_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            sample_zero_q  <= sample_zero_d;
            avg_q          <= avg_d;
            avg_valid_q    <= avg_valid_d;
            cfg_done_q     <= cfg_done_d;
        end
    end

    assign wr_req       = (state_q == StCfgReq);
    assign rd_req       = (state_q == StRdReq);
    assign busy         = (state_q != StIdle);
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign sample_zero  = sample_zero_q;
    assign avg          = avg_q;
    assign avg_valid    = avg_valid_q;
    assign cfg_done     = cfg_done_q;

endmodule

// File: tb/tb_ads_sample_seq.sv
// Directed bench for ads_sample_seq: config sequencing, stability capture, averaging,
// en drop mid-window and reset mid-request.
module tb_ads_sample_seq;

    localparam int unsigned REQ_LEN       = 4;
    localparam int unsigned TXN_WAIT      = 2000;
    localparam int unsigned SAMPLE_PERIOD = 1000;
    localparam int unsigned STABLE_CYC    = 150;
    localparam int unsigned AVG_LOG2      = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] ad_voltage;
    logic        wr_req, rd_req, sample_valid, sample_zero, avg_valid, cfg_done, busy;
    logic [15:0] sample, avg;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int win_start;

    ads_sample_seq #(
        .REQ_LEN      (REQ_LEN),
        .TXN_WAIT     (TXN_WAIT),
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .STABLE_CYC   (STABLE_CYC),
        .AVG_LOG2     (AVG_LOG2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ad_voltage  (ad_voltage),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_zero (sample_zero),
        .avg         (avg),
        .avg_valid   (avg_valid),
        .cfg_done    (cfg_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic play(input logic [15:0] v, input int n);
        ad_voltage = v;
        repeat (n) step();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_wr"}, wr_req, 0);
        check_eq({tag, "_rd"}, rd_req, 0);
        check_eq({tag, "_sample"}, sample, 0);
        check_eq({tag, "_sv"}, sample_valid, 0);
        check_eq({tag, "_sz"}, sample_zero, 0);
        check_eq({tag, "_avg"}, avg, 0);
        check_eq({tag, "_av"}, avg_valid, 0);
        check_eq({tag, "_cfg"}, cfg_done, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    // Waits for rd_req, checks the gap, its width and that no config write sneaks in
    task automatic start_read(input string tag, input int exp_gap);
        int t0 = cyc;
        int w = 0;
        int wr_seen = 0;
        for (int i = 0; i < SAMPLE_PERIOD + 20 && !rd_req; i++) begin
            step();
            if (wr_req) wr_seen++;
        end
        check_eq({tag, "_rd_rise"}, rd_req, 1);
        check_eq({tag, "_gap"}, cyc - t0, exp_gap);
        for (int i = 0; i < REQ_LEN + 20 && rd_req; i++) begin
            if (wr_req) wr_seen++;
            w++;
            step();
        end
        check_eq({tag, "_rd_width"}, w, REQ_LEN);
        check_eq({tag, "_no_wr"}, wr_seen, 0);
        win_start = cyc;
    endtask

    // Waits for the emit strobe and checks it, then checks the strobe drops a cycle later
    task automatic finish_read(input string tag, input logic [15:0] exp_s, input logic exp_z,
                               input logic exp_av, input logic [15:0] exp_avg);
        ad_voltage = 16'h0000;
        for (int i = 0; i < TXN_WAIT + 20 && !sample_valid; i++) step();
        check_eq({tag, "_sv"}, sample_valid, 1);
        check_eq({tag, "_window"}, cyc - win_start, TXN_WAIT);
        check_eq({tag, "_sample"}, sample, exp_s);
        check_eq({tag, "_zero"}, sample_zero, exp_z);
        check_eq({tag, "_av"}, avg_valid, exp_av);
        check_eq({tag, "_avg"}, avg, exp_avg);
        step();
        check_eq({tag, "_sv_drop"}, sample_valid, 0);
        check_eq({tag, "_av_drop"}, avg_valid, 0);
        check_eq({tag, "_hold"}, sample, exp_s);
    endtask

    initial begin
        int wr_first, wr_cnt, cfg_at, t0, rd_seen;
        rst        = 1'b1;
        en         = 1'b0;
        ad_voltage = 16'h0000;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_eq("idle_busy", busy, 0);

        // Config write: wr_req for REQ_LEN cycles, cfg_done after the transaction window
        en       = 1'b1;
        wr_first = -1;
        wr_cnt   = 0;
        cfg_at   = -1;
        t0       = cyc;
        for (int i = 0; i < REQ_LEN + TXN_WAIT + 20 && !cfg_done; i++) begin
            step();
            if (wr_req) begin
                if (wr_first < 0) wr_first = cyc - t0 - 1;
                wr_cnt++;
            end
            if (rd_req) wr_cnt += 100;
        end
        if (cfg_done) cfg_at = cyc - t0 - 1;
        check_eq("wr_first", wr_first, 0);
        check_eq("wr_width", wr_cnt, REQ_LEN);
        check_eq("cfg_at", cfg_at, REQ_LEN + TXN_WAIT);
        check_eq("cfg_busy", busy, 1);

        // Block 1: 0x1234 + 0 + 0x0010 + 0xFFF0 = 4660 -> avg 1165 = 0x048D
        start_read("s1", SAMPLE_PERIOD);
        play(16'h0000, 100);
        play(16'h0091, 100);
        play(16'h0123, 100);
        play(16'h0246, 100);
        play(16'h048D, 100);
        play(16'h091A, 100);
        play(16'h1234, 200);
        finish_read("s1", 16'h1234, 1'b0, 1'b0, 16'h0000);

        start_read("s2", SAMPLE_PERIOD);
        finish_read("s2", 16'h0000, 1'b1, 1'b0, 16'h0000);

        start_read("s3", SAMPLE_PERIOD);
        play(16'h0010, 200);
        finish_read("s3", 16'h0010, 1'b0, 1'b0, 16'h0000);

        start_read("s4", SAMPLE_PERIOD);
        play(16'hFFF0, 200);
        finish_read("s4", 16'hFFF0, 1'b0, 1'b1, 16'h048D);

        // Block 2: 16 + 32 - 16 - 47 = -15 -> floor(-3.75) = -4 = 0xFFFC
        start_read("s5", SAMPLE_PERIOD);
        play(16'h0010, 200);
        finish_read("s5", 16'h0010, 1'b0, 1'b0, 16'h048D);

        start_read("s6", SAMPLE_PERIOD);
        play(16'h0050, 200);
        play(16'h0020, 200);
        finish_read("s6", 16'h0020, 1'b0, 1'b0, 16'h048D);

        start_read("s7", SAMPLE_PERIOD);
        play(16'hFFF0, 200);
        finish_read("s7", 16'hFFF0, 1'b0, 1'b0, 16'h048D);

        start_read("s8", SAMPLE_PERIOD);
        play(16'hFFD1, 200);
        finish_read("s8", 16'hFFD1, 1'b0, 1'b1, 16'hFFFC);

        // Three samples of a new block, en dropped during the third window
        start_read("s9", SAMPLE_PERIOD);
        play(16'h0100, 200);
        finish_read("s9", 16'h0100, 1'b0, 1'b0, 16'hFFFC);

        start_read("s10", SAMPLE_PERIOD);
        play(16'h0200, 200);
        finish_read("s10", 16'h0200, 1'b0, 1'b0, 16'hFFFC);

        start_read("s11", SAMPLE_PERIOD);
        play(16'h0300, 200);
        en = 1'b0;
        finish_read("s11", 16'h0300, 1'b0, 1'b0, 16'hFFFC);
        check_eq("drop_busy", busy, 0);
        rd_seen = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (rd_req || busy) rd_seen++;
        end
        check_eq("drop_quiet", rd_seen, 0);
        check_eq("drop_cfg", cfg_done, 1);

        // Re-enable: straight to the period wait, and the block count restarted
        en = 1'b1;
        start_read("r1", SAMPLE_PERIOD + 1);
        play(16'h0400, 200);
        finish_read("r1", 16'h0400, 1'b0, 1'b0, 16'hFFFC);

        // Reset in the middle of a read request
        for (int i = 0; i < SAMPLE_PERIOD + 20 && !rd_req; i++) step();
        check_eq("rst_rd_rise", rd_req, 1);
        step();
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        step();
        check_eq("rewr_req", wr_req, 1);
        check_eq("rewr_busy", busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
